eth_reset_ctrl: RTL and testbench

Multi-channel reset and link-bring-up controller for the 10G Ethernet top level. It replaces the fixed `!tx_ready` / `!rx_ready` wiring between the transceiver wizard and the MAC/PCS. It sequences the wizard reset-all pulse, debounces per-channel ready signals, and gates per-channel MAC/PCS resets. It also monitors PCS block lock, with timeout-driven RX datapath retries and escalation to a full re-init. It runs in the free-running `init_clk` domain and is parametrised in channel count and timing.

---
 rtl/eth_reset_pkg.sv | 28 ++
 rtl/eth_rx_link_fsm.sv | 144 ++++++++++++++
 rtl/eth_reset_ctrl.sv | 160 ++++++++++++++++
 tb/tb_eth_reset_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_reset_pkg.sv
// rtl/eth_reset_pkg.sv - shared types and helpers for the Ethernet reset/bring-up controller
//
// Purpose: FSM state encodings, counter-width helper and the reset-all counter width.
// Ports: none (package).

package eth_reset_pkg;

  localparam int RESET_ALL_COUNT_W = 8;

  typedef enum logic [1:0] {
    G_RESET_ALL,
    G_WAIT_TX,
    G_RUN
  } g_state_t;

  typedef enum logic [1:0] {
    RX_WAIT_READY,
    RX_WAIT_LOCK,
    RX_RESET,
    RX_UP
  } rx_state_t;

  // Width needed to hold 0..max_val inclusive; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/eth_rx_link_fsm.sv
// rtl/eth_rx_link_fsm.sv - per-channel RX datapath bring-up, lock monitor and retry FSM
//
// Purpose: waits for a stable RX ready, releases the MAC/PCS RX reset, waits for
// block lock with a timeout, pulses the wizard RX datapath reset on timeout and
// requests a full reset-all once the retry budget is spent.
// Ports:
//   init_clk            in   clock
//   reset               in   asynchronous active-high reset
//   i_hold              in   force to RX_WAIT_READY with retries cleared
//   i_rx_ready          in   synchronised RX ready
//   i_lock              in   synchronised PCS block lock
//   o_mac_pcs_rx_reset  out  MAC/PCS RX reset (registered)
//   o_gtwiz_rx_reset    out  wizard RX datapath reset pulse (registered)
//   o_link_up           out  channel locked (registered)
//   o_escalate          out  reset-all request (registered)

module eth_rx_link_fsm
  import eth_reset_pkg::*;
#(
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int STABLE_CYCLES       = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic init_clk,
  input  logic reset,
  input  logic i_hold,
  input  logic i_rx_ready,
  input  logic i_lock,
  output logic o_mac_pcs_rx_reset,
  output logic o_gtwiz_rx_reset,
  output logic o_link_up,
  output logic o_escalate
);

  localparam int STABLE_W  = cnt_w(STABLE_CYCLES);
  localparam int TIMEOUT_W = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int RETRY_W   = cnt_w(MAX_RETRIES);
  localparam int PULSE_W   = cnt_w(RESET_PULSE_CYCLES);

  rx_state_t            r_state;
  logic [STABLE_W-1:0]  r_stable_cnt;
  logic [TIMEOUT_W-1:0] r_timeout_cnt;
  logic [RETRY_W-1:0]   r_retries;
  logic [PULSE_W-1:0]   r_pulse_cnt;
  logic                 r_mac_pcs_rx_reset;
  logic                 r_gtwiz_rx_reset;
  logic                 r_link_up;
  logic                 r_escalate;

  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      r_state            <= RX_WAIT_READY;
      r_stable_cnt       <= '0;
      r_timeout_cnt      <= '0;
      r_retries          <= '0;
      r_pulse_cnt        <= '0;
      r_mac_pcs_rx_reset <= 1'b1;
      r_gtwiz_rx_reset   <= 1'b0;
      r_link_up          <= 1'b0;
      r_escalate         <= 1'b0;
    end else if (i_hold) begin
      r_state            <= RX_WAIT_READY;
      r_stable_cnt       <= '0;
      r_timeout_cnt      <= '0;
      r_retries          <= '0;
      r_pulse_cnt        <= '0;
      r_mac_pcs_rx_reset <= 1'b1;
      r_gtwiz_rx_reset   <= 1'b0;
      r_link_up          <= 1'b0;
      r_escalate         <= 1'b0;
    end else begin
      case (r_state)
        RX_WAIT_READY: begin
          if (!i_rx_ready) begin
            r_stable_cnt <= '0;
          end else if (r_stable_cnt == STABLE_W'(STABLE_CYCLES)) begin
            r_state            <= RX_WAIT_LOCK;
            r_stable_cnt       <= '0;
            r_timeout_cnt      <= '0;
            r_mac_pcs_rx_reset <= 1'b0;
          end else begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
          end
        end
        RX_WAIT_LOCK: begin
          if (!i_rx_ready) begin
            r_state            <= RX_WAIT_READY;
            r_stable_cnt       <= '0;
            r_mac_pcs_rx_reset <= 1'b1;
          end else if (i_lock) begin
            r_state   <= RX_UP;
            r_retries <= '0;
            r_link_up <= 1'b1;
          end else if (!r_escalate) begin
            // Once escalation is requested the channel idles here; the top
            // responds next cycle by holding every channel.
            if (r_timeout_cnt == TIMEOUT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
              if (r_retries < RETRY_W'(MAX_RETRIES)) begin
                r_state            <= RX_RESET;
                r_retries          <= r_retries + 1'b1;
                r_pulse_cnt        <= '0;
                r_gtwiz_rx_reset   <= 1'b1;
                r_mac_pcs_rx_reset <= 1'b1;
              end else begin
                r_escalate <= 1'b1;
              end
            end else begin
              r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
          end
        end
        RX_RESET: begin
          if (r_pulse_cnt == PULSE_W'(RESET_PULSE_CYCLES - 1)) begin
            r_state          <= RX_WAIT_READY;
            r_stable_cnt     <= '0;
            r_gtwiz_rx_reset <= 1'b0;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
          end
        end
        RX_UP: begin
          if (!i_rx_ready) begin
            r_state            <= RX_WAIT_READY;
            r_stable_cnt       <= '0;
            r_link_up          <= 1'b0;
            r_mac_pcs_rx_reset <= 1'b1;
          end else if (!i_lock) begin
            r_state       <= RX_WAIT_LOCK;
            r_timeout_cnt <= '0;
            r_link_up     <= 1'b0;
          end
        end
        default: r_state <= RX_WAIT_READY;
      endcase
    end
  end

  assign o_mac_pcs_rx_reset = r_mac_pcs_rx_reset;
  assign o_gtwiz_rx_reset   = r_gtwiz_rx_reset;
  assign o_link_up          = r_link_up;
  assign o_escalate         = r_escalate;

endmodule

// File: rtl/eth_reset_ctrl.sv
// rtl/eth_reset_ctrl.sv - multi-channel transceiver reset and link bring-up controller
//
// Purpose: sequences the wizard reset-all, gates MAC/PCS TX resets on stable TX
// ready, runs one RX link FSM per channel and escalates to reset-all on demand.
// Ports:
//   init_clk            in   free-running clock, sole clock domain
//   reset               in   asynchronous active-high reset
//   i_gtwiz_tx_ready    in   [N] per-channel TX ready (async)
//   i_gtwiz_rx_ready    in   [N] per-channel RX ready (async)
//   i_block_lock        in   [N] PCS RX block lock (async)
//   o_gtwiz_reset_all   out  wizard reset-all
//   o_gtwiz_rx_reset    out  [N] RX datapath reset pulse
//   o_mac_pcs_tx_reset  out  [N] MAC/PCS TX reset
//   o_mac_pcs_rx_reset  out  [N] MAC/PCS RX reset
//   o_link_up           out  [N] channel RX locked
//   o_reset_all_count   out  [8] escalated reset-alls, saturating

module eth_reset_ctrl
  import eth_reset_pkg::*;
#(
  parameter int N_CHANNELS          = 2,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int STABLE_CYCLES       = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                         init_clk,
  input  logic                         reset,
  input  logic [N_CHANNELS-1:0]        i_gtwiz_tx_ready,
  input  logic [N_CHANNELS-1:0]        i_gtwiz_rx_ready,
  input  logic [N_CHANNELS-1:0]        i_block_lock,
  output logic                         o_gtwiz_reset_all,
  output logic [N_CHANNELS-1:0]        o_gtwiz_rx_reset,
  output logic [N_CHANNELS-1:0]        o_mac_pcs_tx_reset,
  output logic [N_CHANNELS-1:0]        o_mac_pcs_rx_reset,
  output logic [N_CHANNELS-1:0]        o_link_up,
  output logic [RESET_ALL_COUNT_W-1:0] o_reset_all_count
);

  localparam int STABLE_W = cnt_w(STABLE_CYCLES);
  localparam int PULSE_W  = cnt_w(RESET_PULSE_CYCLES);

  // Two-flop synchronisers for all asynchronous inputs.
  logic [N_CHANNELS-1:0] r_tx_meta, r_tx_sync;
  logic [N_CHANNELS-1:0] r_rx_meta, r_rx_sync;
  logic [N_CHANNELS-1:0] r_lock_meta, r_lock_sync;

  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      r_tx_meta   <= '0;
      r_tx_sync   <= '0;
      r_rx_meta   <= '0;
      r_rx_sync   <= '0;
      r_lock_meta <= '0;
      r_lock_sync <= '0;
    end else begin
      r_tx_meta   <= i_gtwiz_tx_ready;
      r_tx_sync   <= r_tx_meta;
      r_rx_meta   <= i_gtwiz_rx_ready;
      r_rx_sync   <= r_rx_meta;
      r_lock_meta <= i_block_lock;
      r_lock_sync <= r_lock_meta;
    end
  end

  g_state_t                      r_g_state;
  logic [STABLE_W-1:0]           r_tx_stable_cnt;
  logic [PULSE_W-1:0]            r_pulse_cnt;
  logic                          r_reset_all;
  logic [N_CHANNELS-1:0]         r_tx_reset;
  logic [RESET_ALL_COUNT_W-1:0]  r_reset_all_count;

  logic [N_CHANNELS-1:0] w_rx_escalate;
  logic                  w_all_tx_ready;
  logic                  w_escalate;
  logic                  w_rx_hold;

  assign w_all_tx_ready = &r_tx_sync;
  // Several channels escalating together collapse into one request.
  assign w_escalate     = |w_rx_escalate;
  // Holding on the escalation request itself lets every channel drop in the
  // same cycle that reset-all reasserts.
  assign w_rx_hold      = (r_g_state == G_RESET_ALL) || w_escalate;

  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      r_g_state         <= G_RESET_ALL;
      r_tx_stable_cnt   <= '0;
      r_pulse_cnt       <= '0;
      r_reset_all       <= 1'b1;
      r_tx_reset        <= '1;
      r_reset_all_count <= '0;
    end else if (w_escalate) begin
      r_g_state       <= G_RESET_ALL;
      r_tx_stable_cnt <= '0;
      r_pulse_cnt     <= '0;
      r_reset_all     <= 1'b1;
      r_tx_reset      <= '1;
      if (r_reset_all_count != '1) begin
        r_reset_all_count <= r_reset_all_count + 1'b1;
      end
    end else begin
      case (r_g_state)
        G_RESET_ALL: begin
          if (r_pulse_cnt == PULSE_W'(RESET_PULSE_CYCLES - 1)) begin
            r_g_state       <= G_WAIT_TX;
            r_pulse_cnt     <= '0;
            r_tx_stable_cnt <= '0;
            r_reset_all     <= 1'b0;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
          end
        end
        G_WAIT_TX: begin
          if (!w_all_tx_ready) begin
            r_tx_stable_cnt <= '0;
          end else if (r_tx_stable_cnt == STABLE_W'(STABLE_CYCLES)) begin
            r_g_state       <= G_RUN;
            r_tx_stable_cnt <= '0;
            r_tx_reset      <= '0;
          end else begin
            r_tx_stable_cnt <= r_tx_stable_cnt + 1'b1;
          end
        end
        G_RUN: begin
          if (!w_all_tx_ready) begin
            r_g_state       <= G_WAIT_TX;
            r_tx_stable_cnt <= '0;
            r_tx_reset      <= '1;
          end
        end
        default: r_g_state <= G_RESET_ALL;
      endcase
    end
  end

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_rx
    eth_rx_link_fsm #(
      .RESET_PULSE_CYCLES (RESET_PULSE_CYCLES),
      .STABLE_CYCLES      (STABLE_CYCLES),
      .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
      .MAX_RETRIES        (MAX_RETRIES)
    ) u_rx (
      .init_clk          (init_clk),
      .reset             (reset),
      .i_hold            (w_rx_hold),
      .i_rx_ready        (r_rx_sync[c]),
      .i_lock            (r_lock_sync[c]),
      .o_mac_pcs_rx_reset(o_mac_pcs_rx_reset[c]),
      .o_gtwiz_rx_reset  (o_gtwiz_rx_reset[c]),
      .o_link_up         (o_link_up[c]),
      .o_escalate        (w_rx_escalate[c])
    );
  end

  assign o_gtwiz_reset_all  = r_reset_all;
  assign o_mac_pcs_tx_reset = r_tx_reset;
  assign o_reset_all_count  = r_reset_all_count;

endmodule

// File: tb/tb_eth_reset_ctrl.sv
// tb/tb_eth_reset_ctrl.sv - self-checking bench for eth_reset_ctrl

module tb_eth_reset_ctrl;

  localparam int N = 2;
  localparam int P = 4;
  localparam int S = 8;
  localparam int T = 32;
  localparam int R = 2;

  logic         init_clk = 1'b0;
  logic         reset    = 1'b1;
  logic [N-1:0] tx_ready = '0;
  logic [N-1:0] rx_ready = '0;
  logic [N-1:0] lock     = '0;

  logic         reset_all;
  logic [N-1:0] gt_rx_reset;
  logic [N-1:0] tx_rst;
  logic [N-1:0] rx_rst;
  logic [N-1:0] link_up;
  logic [7:0]   ra_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  always #5 init_clk = ~init_clk;

  eth_reset_ctrl #(
    .N_CHANNELS         (N),
    .RESET_PULSE_CYCLES (P),
    .STABLE_CYCLES      (S),
    .LOCK_TIMEOUT_CYCLES(T),
    .MAX_RETRIES        (R)
  ) dut (
    .init_clk          (init_clk),
    .reset             (reset),
    .i_gtwiz_tx_ready  (tx_ready),
    .i_gtwiz_rx_ready  (rx_ready),
    .i_block_lock      (lock),
    .o_gtwiz_reset_all (reset_all),
    .o_gtwiz_rx_reset  (gt_rx_reset),
    .o_mac_pcs_tx_reset(tx_rst),
    .o_mac_pcs_rx_reset(rx_rst),
    .o_link_up         (link_up),
    .o_reset_all_count (ra_count)
  );

  task automatic step();
    @(posedge init_clk);
    #1;
  endtask

  // Reset, release, wait out the reset-all pulse, then present ready/lock.
  task automatic bring_up(input logic [N-1:0] lock_val);
    int n;
    reset = 1'b1; tx_ready = '0; rx_ready = '0; lock = '0;
    step(); step();
    reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (reset_all === 1'b0) begin n = i; break; end
    end
    n_checks++;
    if (n == 0) begin
      n_errors++;
      $display("FAIL bring_up reset_all release: got no release in 20 cycles, expected release");
    end
    tx_ready = '1; rx_ready = '1; lock = lock_val;
  endtask

  task automatic test_reset();
    reset = 1'b1; tx_ready = '0; rx_ready = '0; lock = '0;
    step(); step();
    exp_q.push_back(32'd1); exp_q.push_back(32'd3); exp_q.push_back(32'd3);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (32'(reset_all) !== e) begin n_errors++; $display("FAIL reset reset_all: got %0d expected %0d", reset_all, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(tx_rst) !== e) begin n_errors++; $display("FAIL reset tx_reset: got %0d expected %0d", tx_rst, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(rx_rst) !== e) begin n_errors++; $display("FAIL reset rx_reset: got %0d expected %0d", rx_rst, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(gt_rx_reset) !== e) begin n_errors++; $display("FAIL reset gt_rx_reset: got %0d expected %0d", gt_rx_reset, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(link_up) !== e) begin n_errors++; $display("FAIL reset link_up: got %0d expected %0d", link_up, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(ra_count) !== e) begin n_errors++; $display("FAIL reset count: got %0d expected %0d", ra_count, e); end
  endtask

  // Change indices count posedges after the drive; the first posedge is 1.
  task automatic test_power_up();
    int n_ra, n_tx, n_rx, n_lk;
    exp_q.push_back(32'(P));
    reset = 1'b0;
    n_ra = 0;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (reset_all === 1'b0) begin n_ra = i; break; end
    end
    e = exp_q.pop_front(); n_checks++;
    if (32'(n_ra) !== e) begin n_errors++; $display("FAIL power_up reset_all width: got %0d expected %0d", n_ra, e); end

    exp_q.push_back(32'(S + 3)); exp_q.push_back(32'(S + 3)); exp_q.push_back(32'(S + 4));
    tx_ready = '1; rx_ready = '1; lock = '1;
    n_tx = 0; n_rx = 0; n_lk = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (n_tx == 0 && tx_rst === 2'b00) n_tx = i;
      if (n_rx == 0 && rx_rst === 2'b00) n_rx = i;
      if (n_lk == 0 && link_up === 2'b11) n_lk = i;
      if (n_tx != 0 && n_rx != 0 && n_lk != 0) break;
    end
    e = exp_q.pop_front(); n_checks++;
    if (32'(n_tx) !== e) begin n_errors++; $display("FAIL power_up tx_reset release: got %0d expected %0d", n_tx, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(n_rx) !== e) begin n_errors++; $display("FAIL power_up rx_reset release: got %0d expected %0d", n_rx, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(n_lk) !== e) begin n_errors++; $display("FAIL power_up link_up: got %0d expected %0d", n_lk, e); end
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (32'(ra_count) !== e) begin n_errors++; $display("FAIL power_up count: got %0d expected %0d", ra_count, e); end
  endtask

  task automatic test_ready_glitch();
    int n;
    bring_up('1);
    repeat (4) step();
    tx_ready[0] = 1'b0;
    step();
    tx_ready[0] = 1'b1;
    exp_q.push_back(32'(S + 3));
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (tx_rst === 2'b00) begin n = i; break; end
    end
    e = exp_q.pop_front(); n_checks++;
    if (32'(n) !== e) begin n_errors++; $display("FAIL glitch tx_reset release: got %0d expected %0d", n, e); end
  endtask

  task automatic test_lock_loss();
    int n, gt0, drops1;
    bring_up('1);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (link_up === 2'b11) begin n = i; break; end
    end
    n_checks++;
    if (n == 0) begin n_errors++; $display("FAIL lock_loss link up: got %0d expected 3", link_up); end
    gt0 = 0; drops1 = 0;
    exp_q.push_back(32'd3); exp_q.push_back(32'd3); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    lock[0] = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (gt_rx_reset[0] !== 1'b0) gt0++;
      if (link_up[1] !== 1'b1) drops1++;
      if (link_up[0] === 1'b0) begin n = i; break; end
    end
    e = exp_q.pop_front(); n_checks++;
    if (32'(n) !== e) begin n_errors++; $display("FAIL lock_loss link fall: got %0d expected %0d", n, e); end
    repeat (2) begin
      step();
      if (gt_rx_reset[0] !== 1'b0) gt0++;
    end
    lock[0] = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (gt_rx_reset[0] !== 1'b0) gt0++;
      if (link_up[1] !== 1'b1) drops1++;
      if (link_up[0] === 1'b1) begin n = i; break; end
    end
    e = exp_q.pop_front(); n_checks++;
    if (32'(n) !== e) begin n_errors++; $display("FAIL lock_loss link rise: got %0d expected %0d", n, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(gt0) !== e) begin n_errors++; $display("FAIL lock_loss rx pulse cycles: got %0d expected %0d", gt0, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(drops1) !== e) begin n_errors++; $display("FAIL lock_loss ch1 link drops: got %0d expected %0d", drops1, e); end
  endtask

  int  drops0;
  logic up0;

  task automatic test_lock_retry();
    int low_cnt, width;
    bring_up(2'b01);
    drops0 = 0; up0 = 1'b0;
    for (int p = 0; p < R; p++) begin
      exp_q.push_back(32'(T)); exp_q.push_back(32'(P));
      low_cnt = 0;
      for (int i = 1; i <= 200; i++) begin
        step();
        if (up0 && link_up[0] !== 1'b1) drops0++;
        if (link_up[0] === 1'b1) up0 = 1'b1;
        if (gt_rx_reset[1] === 1'b1) break;
        if (rx_rst[1] === 1'b0) low_cnt++;
      end
      width = (gt_rx_reset[1] === 1'b1) ? 1 : 0;
      for (int i = 1; i <= 20 && width != 0; i++) begin
        step();
        if (up0 && link_up[0] !== 1'b1) drops0++;
        if (gt_rx_reset[1] === 1'b1) width++;
        else break;
      end
      e = exp_q.pop_front(); n_checks++;
      if (32'(low_cnt) !== e) begin n_errors++; $display("FAIL retry %0d wait_lock cycles: got %0d expected %0d", p, low_cnt, e); end
      e = exp_q.pop_front(); n_checks++;
      if (32'(width) !== e) begin n_errors++; $display("FAIL retry %0d rx pulse width: got %0d expected %0d", p, width, e); end
    end
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (32'(drops0) !== e || !up0) begin n_errors++; $display("FAIL retry ch0 link drops: got %0d (up %0d) expected %0d", drops0, up0, e); end
  endtask

  task automatic test_escalation();
    int gt1, width;
    logic seen;
    gt1 = 0; seen = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'(P));
    for (int i = 1; i <= 200; i++) begin
      step();
      if (reset_all === 1'b1) begin seen = 1'b1; break; end
      if (gt_rx_reset[1] !== 1'b0) gt1++;
    end
    e = exp_q.pop_front(); n_checks++;
    if (32'(gt1) !== e || !seen) begin n_errors++; $display("FAIL escalation extra rx pulse cycles: got %0d (seen %0d) expected %0d", gt1, seen, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(ra_count) !== e) begin n_errors++; $display("FAIL escalation count: got %0d expected %0d", ra_count, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(link_up) !== e) begin n_errors++; $display("FAIL escalation link_up: got %0d expected %0d", link_up, e); end
    width = seen ? 1 : 0;
    for (int i = 1; i <= 20 && seen; i++) begin
      step();
      if (reset_all === 1'b1) width++;
      else break;
    end
    e = exp_q.pop_front(); n_checks++;
    if (32'(width) !== e) begin n_errors++; $display("FAIL escalation reset_all width: got %0d expected %0d", width, e); end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (tx_rst === 2'b00) begin n = i; break; end
    end
    n_checks++;
    if (n == 0) begin n_errors++; $display("FAIL mid_reset reach run: got tx_reset %0d expected 0", tx_rst); end
    #3;
    reset = 1'b1;
    #1;
    exp_q.push_back(32'd1); exp_q.push_back(32'd3); exp_q.push_back(32'd3);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); n_checks++;
    if (32'(reset_all) !== e) begin n_errors++; $display("FAIL mid_reset reset_all: got %0d expected %0d", reset_all, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(tx_rst) !== e) begin n_errors++; $display("FAIL mid_reset tx_reset: got %0d expected %0d", tx_rst, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(rx_rst) !== e) begin n_errors++; $display("FAIL mid_reset rx_reset: got %0d expected %0d", rx_rst, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(gt_rx_reset) !== e) begin n_errors++; $display("FAIL mid_reset gt_rx_reset: got %0d expected %0d", gt_rx_reset, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(link_up) !== e) begin n_errors++; $display("FAIL mid_reset link_up: got %0d expected %0d", link_up, e); end
    e = exp_q.pop_front(); n_checks++;
    if (32'(ra_count) !== e) begin n_errors++; $display("FAIL mid_reset count: got %0d expected %0d", ra_count, e); end

    lock = '1;
    step();
    exp_q.push_back(32'(P)); exp_q.push_back(32'd3);
    reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (reset_all === 1'b0) begin n = i; break; end
    end
    e = exp_q.pop_front(); n_checks++;
    if (32'(n) !== e) begin n_errors++; $display("FAIL mid_reset restart reset_all width: got %0d expected %0d", n, e); end
    for (int i = 1; i <= 80; i++) begin
      step();
      if (link_up === 2'b11) break;
    end
    e = exp_q.pop_front(); n_checks++;
    if (32'(link_up) !== e) begin n_errors++; $display("FAIL mid_reset restart link_up: got %0d expected %0d", link_up, e); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_ready_glitch();
    test_lock_loss();
    test_lock_retry();
    test_escalation();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
